// File: rtl/qr_finder_pkg.sv
// Shared types and constants for the QR finder-pattern scan path.
// Holds the scheduler state encoding and frame geometry defaults.
package qr_finder_pkg;

    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int ADDR_W       = 20;
    localparam int WDOG_W       = 21;

    typedef enum logic [2:0] {
        IDLE,
        H_RST,
        H_RUN,
        V_RST,
        V_RUN,
        DONE,
        ERR
    } scan_state_t;

    // Both run phases share the frame-buffer port and the watchdog.
    function automatic logic is_run(scan_state_t s);
        return (s == H_RUN) || (s == V_RUN);
    endfunction

endpackage

// File: rtl/finder_scan_scheduler_if.sv
// Signal bundle between the scan scheduler, the frame-buffer BRAM, both
// ratio finders and the QR locator. master = scheduler side.
interface finder_scan_scheduler_if
    import qr_finder_pkg::*;
#(
    parameter int WIDTH  = FRAME_WIDTH,
    parameter int HEIGHT = FRAME_HEIGHT
) ();

    logic              start_in;
    logic              abort_in;
    logic              bram_dout_in;
    logic [ADDR_W-1:0] bram_addr_out;
    logic [ADDR_W-1:0] h_addr_in;
    logic [HEIGHT-1:0] h_enc_in;
    logic              h_valid_in;
    logic [ADDR_W-1:0] v_addr_in;
    logic [WIDTH-1:0]  v_enc_in;
    logic              v_valid_in;
    logic              h_rst_out;
    logic              h_start_out;
    logic              h_pixel_out;
    logic              v_rst_out;
    logic              v_start_out;
    logic              v_pixel_out;
    logic              busy_out;
    logic [HEIGHT-1:0] h_result_out;
    logic [WIDTH-1:0]  v_result_out;
    logic              done_out;
    logic              error_out;

    modport master (
        input  start_in, abort_in, bram_dout_in,
        input  h_addr_in, h_enc_in, h_valid_in,
        input  v_addr_in, v_enc_in, v_valid_in,
        output bram_addr_out,
        output h_rst_out, h_start_out, h_pixel_out,
        output v_rst_out, v_start_out, v_pixel_out,
        output busy_out, h_result_out, v_result_out, done_out, error_out
    );

    modport slave (
        output start_in, abort_in, bram_dout_in,
        output h_addr_in, h_enc_in, h_valid_in,
        output v_addr_in, v_enc_in, v_valid_in,
        input  bram_addr_out,
        input  h_rst_out, h_start_out, h_pixel_out,
        input  v_rst_out, v_start_out, v_pixel_out,
        input  busy_out, h_result_out, v_result_out, done_out, error_out
    );

endinterface

// File: rtl/phase_watchdog.sv
// Cycle counter bounding the length of one scan phase; expired is raised
// in the cycle where the count reaches TIMEOUT-1 while enabled.
module phase_watchdog #(
    parameter int TIMEOUT = 1048576,
    parameter int CNT_W   = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/finder_scan_scheduler.sv
// Runs one horizontal then one vertical finder scan over a captured frame,
// sharing the BRAM read port and latching both encoding vectors.
module finder_scan_scheduler
    import qr_finder_pkg::*;
#(
    parameter int WIDTH   = FRAME_WIDTH,
    parameter int HEIGHT  = FRAME_HEIGHT,
    parameter int TIMEOUT = 1048576
) (
    input logic                     clk_in,
    input logic                     rst_n_in,
    finder_scan_scheduler_if.master bus
);

    scan_state_t       state_reg;
    scan_state_t       state_next;
    logic              h_rst_reg;
    logic              h_start_reg;
    logic              v_rst_reg;
    logic              v_start_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic [HEIGHT-1:0] h_result_reg;
    logic [WIDTH-1:0]  v_result_reg;
    logic              expired;

    phase_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (WDOG_W)
    ) u_watchdog (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .clear   (!is_run(state_reg)),
        .enable  (is_run(state_reg)),
        .expired (expired)
    );

    // Priority inside a run phase: abort, then valid, then timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start_in) state_next = H_RST;
            H_RST:   state_next = H_RUN;
            H_RUN:   if (bus.h_valid_in) state_next = V_RST;
                     else if (expired)   state_next = ERR;
            V_RST:   state_next = V_RUN;
            V_RUN:   if (bus.v_valid_in) state_next = DONE;
                     else if (expired)   state_next = ERR;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.abort_in && (state_reg != IDLE)) begin
            state_next = IDLE;
        end
    end

    // Control outputs are decoded from the next state so they are registers
    // that line up exactly with state_reg.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= IDLE;
            h_rst_reg    <= 1'b1;
            h_start_reg  <= 1'b0;
            v_rst_reg    <= 1'b1;
            v_start_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            h_result_reg <= '0;
            v_result_reg <= '0;
        end else begin
            state_reg   <= state_next;
            h_rst_reg   <= (state_next != H_RUN);
            h_start_reg <= (state_next == H_RUN);
            v_rst_reg   <= (state_next != V_RUN);
            v_start_reg <= (state_next == V_RUN);
            busy_reg    <= (state_next != IDLE);
            done_reg    <= (state_next == DONE);
            error_reg   <= (state_next == ERR);
            if ((state_reg == H_RUN) && (state_next == V_RST)) begin
                h_result_reg <= bus.h_enc_in;
            end
            if ((state_reg == V_RUN) && (state_next == DONE)) begin
                v_result_reg <= bus.v_enc_in;
            end
        end
    end

    // The finders wait two cycles for BRAM data themselves, so no pipelining here.
    always_comb begin
        bus.bram_addr_out = '0;
        bus.h_pixel_out   = 1'b1;
        bus.v_pixel_out   = 1'b1;
        if (state_reg == H_RUN) begin
            bus.bram_addr_out = bus.h_addr_in;
            bus.h_pixel_out   = bus.bram_dout_in;
        end else if (state_reg == V_RUN) begin
            bus.bram_addr_out = bus.v_addr_in;
            bus.v_pixel_out   = bus.bram_dout_in;
        end
    end

    assign bus.h_rst_out    = h_rst_reg;
    assign bus.h_start_out  = h_start_reg;
    assign bus.v_rst_out    = v_rst_reg;
    assign bus.v_start_out  = v_start_reg;
    assign bus.busy_out     = busy_reg;
    assign bus.done_out     = done_reg;
    assign bus.error_out    = error_reg;
    assign bus.h_result_out = h_result_reg;
    assign bus.v_result_out = v_result_reg;

endmodule

// File: tb/tb_finder_scan_scheduler.sv
// Scoreboard bench: dut_a (long timeout) covers scan, abort and reset;
// dut_b (TIMEOUT=16) covers the watchdog boundary.
module tb_finder_scan_scheduler;
    import qr_finder_pkg::*;

    localparam int W = FRAME_WIDTH;
    localparam int H = FRAME_HEIGHT;

    typedef struct {
        logic         is_err;
        logic [H-1:0] h_exp;
        logic [W-1:0] v_exp;
    } txn_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rst_n_b  = 1'b0;
    always #5 clk_in = ~clk_in;

    finder_scan_scheduler_if #(.WIDTH(W), .HEIGHT(H)) bus_a ();
    finder_scan_scheduler_if #(.WIDTH(W), .HEIGHT(H)) bus_b ();

    finder_scan_scheduler #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(1024)) dut_a (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus_a)
    );

    finder_scan_scheduler #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(16)) dut_b (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_b),
        .bus      (bus_b)
    );

    txn_t q_a[$];
    txn_t q_b[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_a    = 0;
    int   err_a     = 0;
    int   done_b    = 0;
    int   err_b     = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    always @(negedge clk_in) begin : mon_a
        txn_t t;
        if (bus_a.done_out || bus_a.error_out) begin
            if (bus_a.done_out)  done_a++;
            if (bus_a.error_out) err_a++;
            check_val("a_txn_pending", W'(q_a.size() > 0), W'(1));
            if (q_a.size() > 0) begin
                t = q_a.pop_front();
                check_val("a_kind", W'(bus_a.error_out), W'(t.is_err));
                check_val("a_h_result", W'(bus_a.h_result_out), W'(t.h_exp));
                check_val("a_v_result", bus_a.v_result_out, t.v_exp);
                $display("TXN dut_a %s at %0t", bus_a.error_out ? "error" : "done", $time);
            end
        end
    end

    always @(negedge clk_in) begin : mon_b
        txn_t t;
        if (bus_b.done_out || bus_b.error_out) begin
            if (bus_b.done_out)  done_b++;
            if (bus_b.error_out) err_b++;
            check_val("b_txn_pending", W'(q_b.size() > 0), W'(1));
            if (q_b.size() > 0) begin
                t = q_b.pop_front();
                check_val("b_kind", W'(bus_b.error_out), W'(t.is_err));
                check_val("b_h_result", W'(bus_b.h_result_out), W'(t.h_exp));
                check_val("b_v_result", bus_b.v_result_out, t.v_exp);
                $display("TXN dut_b %s at %0t", bus_b.error_out ? "error" : "done", $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "bench timed out");
    end

    initial begin
        txn_t         t;
        logic [H-1:0] h_exp;
        logic [W-1:0] v_exp;
        logic [H-1:0] h_prev;
        logic [W-1:0] v_prev;

        bus_a.start_in = 0; bus_a.abort_in = 0; bus_a.bram_dout_in = 0;
        bus_a.h_addr_in = '0; bus_a.h_enc_in = '0; bus_a.h_valid_in = 0;
        bus_a.v_addr_in = '0; bus_a.v_enc_in = '0; bus_a.v_valid_in = 0;
        bus_b.start_in = 0; bus_b.abort_in = 0; bus_b.bram_dout_in = 0;
        bus_b.h_addr_in = '0; bus_b.h_enc_in = '0; bus_b.h_valid_in = 0;
        bus_b.v_addr_in = '0; bus_b.v_enc_in = '0; bus_b.v_valid_in = 0;

        // Reset values
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_val("rst_h_rst", W'(bus_a.h_rst_out), W'(1));
        check_val("rst_v_rst", W'(bus_a.v_rst_out), W'(1));
        check_val("rst_busy", W'(bus_a.busy_out), W'(0));
        check_val("rst_done", W'(bus_a.done_out), W'(0));
        check_val("rst_addr", W'(bus_a.bram_addr_out), W'(0));
        check_val("rst_h_result", W'(bus_a.h_result_out), W'(0));
        rst_n_in = 1'b1;
        rst_n_b  = 1'b1;

        // Full scan on dut_a: h valid after ~100 cycles, v valid after ~200
        tick(); bus_a.start_in = 1;
        tick(); bus_a.start_in = 0;
        @(negedge clk_in);
        check_val("hrst_busy", W'(bus_a.busy_out), W'(1));
        check_val("hrst_h_rst", W'(bus_a.h_rst_out), W'(1));
        check_val("hrst_h_start", W'(bus_a.h_start_out), W'(0));
        tick();
        bus_a.h_addr_in = 20'h12345; bus_a.v_addr_in = 20'h0ABCD; bus_a.bram_dout_in = 0;
        bus_a.start_in = 1;
        bus_a.v_valid_in = 1; bus_a.v_enc_in = '1;
        @(negedge clk_in);
        check_val("hrun_h_rst", W'(bus_a.h_rst_out), W'(0));
        check_val("hrun_h_start", W'(bus_a.h_start_out), W'(1));
        check_val("hrun_addr", W'(bus_a.bram_addr_out), W'(20'h12345));
        check_val("hrun_v_pixel", W'(bus_a.v_pixel_out), W'(1));
        check_val("hrun_v_rst", W'(bus_a.v_rst_out), W'(1));
        check_val("hrun_h_pixel0", W'(bus_a.h_pixel_out), W'(0));
        tick();
        bus_a.start_in = 0; bus_a.v_valid_in = 0; bus_a.bram_dout_in = 1;
        @(negedge clk_in);
        check_val("hrun_h_pixel1", W'(bus_a.h_pixel_out), W'(1));
        check_val("hrun_start_ignored", W'(bus_a.h_start_out), W'(1));
        repeat (97) tick();
        h_exp = '0; h_exp[37] = 1'b1;
        bus_a.h_valid_in = 1; bus_a.h_enc_in = h_exp;
        tick();
        bus_a.h_valid_in = 0; bus_a.h_enc_in = '1;
        @(negedge clk_in);
        check_val("vrst_v_rst", W'(bus_a.v_rst_out), W'(1));
        check_val("vrst_h_rst", W'(bus_a.h_rst_out), W'(1));
        check_val("vrst_h_latched", W'(bus_a.h_result_out), W'(h_exp));
        check_val("vrst_v_ignored", bus_a.v_result_out, W'(0));
        tick();
        @(negedge clk_in);
        check_val("vrun_v_start", W'(bus_a.v_start_out), W'(1));
        check_val("vrun_v_rst", W'(bus_a.v_rst_out), W'(0));
        check_val("vrun_addr", W'(bus_a.bram_addr_out), W'(20'h0ABCD));
        check_val("vrun_h_pixel", W'(bus_a.h_pixel_out), W'(1));
        check_val("vrun_v_pixel", W'(bus_a.v_pixel_out), W'(1));
        repeat (198) tick();
        v_exp = '0; v_exp[600] = 1'b1;
        bus_a.v_valid_in = 1; bus_a.v_enc_in = v_exp;
        t.is_err = 0; t.h_exp = h_exp; t.v_exp = v_exp;
        q_a.push_back(t);
        tick();
        bus_a.v_valid_in = 0; bus_a.v_enc_in = '0;
        @(negedge clk_in);
        check_val("done_pulse", W'(bus_a.done_out), W'(1));
        tick();
        @(negedge clk_in);
        check_val("done_single", W'(bus_a.done_out), W'(0));
        check_val("done_idle_busy", W'(bus_a.busy_out), W'(0));
        check_val("done_count", W'(done_a), W'(1));

        // dut_b: no h valid -> error 16 cycles after H_RUN entry
        tick(); bus_b.start_in = 1;
        t.is_err = 1; t.h_exp = '0; t.v_exp = '0;
        q_b.push_back(t);
        tick(); bus_b.start_in = 0;
        tick();
        @(negedge clk_in);
        check_val("to_hrun_entry", W'(bus_b.h_start_out), W'(1));
        repeat (15) @(negedge clk_in);
        check_val("to_no_early_err", W'(bus_b.error_out), W'(0));
        @(negedge clk_in);
        check_val("to_err_pulse", W'(bus_b.error_out), W'(1));
        @(negedge clk_in);
        check_val("to_err_single", W'(bus_b.error_out), W'(0));
        check_val("to_idle", W'(bus_b.busy_out), W'(0));

        // dut_b: valid in the same cycle as expiry -> valid wins, then V timeout
        h_prev = '0; h_prev[200] = 1'b1;
        tick(); bus_b.start_in = 1;
        t.is_err = 1; t.h_exp = h_prev; t.v_exp = '0;
        q_b.push_back(t);
        tick(); bus_b.start_in = 0;
        tick();
        repeat (15) tick();
        bus_b.h_valid_in = 1; bus_b.h_enc_in = h_prev;
        tick();
        bus_b.h_valid_in = 0; bus_b.h_enc_in = '0;
        @(negedge clk_in);
        check_val("tie_no_err", W'(bus_b.error_out), W'(0));
        check_val("tie_vrst", W'(bus_b.v_rst_out), W'(1));
        check_val("tie_busy", W'(bus_b.busy_out), W'(1));
        check_val("tie_h_latched", W'(bus_b.h_result_out), W'(h_prev));
        repeat (20) tick();
        check_val("b_err_count", W'(err_b), W'(2));

        // dut_a: abort mid V_RUN
        h_prev = '0; h_prev[5] = 1'b1;
        tick(); bus_a.start_in = 1;
        tick(); bus_a.start_in = 0;
        tick();
        repeat (9) tick();
        bus_a.h_valid_in = 1; bus_a.h_enc_in = h_prev;
        tick(); bus_a.h_valid_in = 0;
        tick();
        repeat (4) tick();
        bus_a.abort_in = 1;
        tick(); bus_a.abort_in = 0;
        @(negedge clk_in);
        check_val("abort_busy", W'(bus_a.busy_out), W'(0));
        check_val("abort_v_rst", W'(bus_a.v_rst_out), W'(1));
        check_val("abort_no_done", W'(bus_a.done_out), W'(0));
        check_val("abort_no_err", W'(bus_a.error_out), W'(0));
        check_val("abort_h_result", W'(bus_a.h_result_out), W'(h_prev));
        check_val("abort_v_result", bus_a.v_result_out, v_exp);
        repeat (5) tick();

        // dut_a: asynchronous reset mid H_RUN, then a clean scan
        tick(); bus_a.start_in = 1;
        tick(); bus_a.start_in = 0;
        tick();
        repeat (5) tick();
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check_val("arst_busy", W'(bus_a.busy_out), W'(0));
        check_val("arst_h_rst", W'(bus_a.h_rst_out), W'(1));
        check_val("arst_h_start", W'(bus_a.h_start_out), W'(0));
        check_val("arst_addr", W'(bus_a.bram_addr_out), W'(0));
        check_val("arst_h_result", W'(bus_a.h_result_out), W'(0));
        check_val("arst_v_result", bus_a.v_result_out, W'(0));
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        h_prev = '0; h_prev[100] = 1'b1;
        v_prev = '0; v_prev[7] = 1'b1;
        tick(); bus_a.start_in = 1;
        tick(); bus_a.start_in = 0;
        tick();
        repeat (20) tick();
        bus_a.h_valid_in = 1; bus_a.h_enc_in = h_prev;
        tick(); bus_a.h_valid_in = 0;
        tick();
        repeat (30) tick();
        bus_a.v_valid_in = 1; bus_a.v_enc_in = v_prev;
        t.is_err = 0; t.h_exp = h_prev; t.v_exp = v_prev;
        q_a.push_back(t);
        tick(); bus_a.v_valid_in = 0;
        repeat (4) tick();
        check_val("final_done_a", W'(done_a), W'(2));
        check_val("final_err_a", W'(err_a), W'(0));
        check_val("final_done_b", W'(done_b), W'(0));
        check_val("final_q_a", W'(q_a.size()), W'(0));
        check_val("final_q_b", W'(q_b.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
